// File: rtl/ldtu_data_encoder_if.sv
// Sample-in / word-out bundle for ldtu_data_encoder.
// master: the surrounding logic (sample source, serializer, monitoring).
// slave : the encoder itself.
// Ports grouped here:
//   sample_valid, DATA_to_enc[12:0], baseline_flag, flush  -> encoder
//   DATA_32[31:0], word_valid, fifo_full, overflow          <- encoder
//   word_ready                                              -> encoder
//   ovf_cnt[7:0] (only with LDTU_ENC_OVF_CNT_EN)            <- encoder
interface ldtu_data_encoder_if;
  logic        sample_valid;
  logic [12:0] DATA_to_enc;
  logic        baseline_flag;
  logic        flush;
  logic [31:0] DATA_32;
  logic        word_valid;
  logic        word_ready;
  logic        fifo_full;
  logic        overflow;
`ifdef LDTU_ENC_OVF_CNT_EN
  logic [7:0]  ovf_cnt;
`endif

  modport master (
    output sample_valid, DATA_to_enc, baseline_flag, flush, word_ready,
    input  DATA_32, word_valid, fifo_full, overflow
`ifdef LDTU_ENC_OVF_CNT_EN
    , input ovf_cnt
`endif
  );

  modport slave (
    input  sample_valid, DATA_to_enc, baseline_flag, flush, word_ready,
    output DATA_32, word_valid, fifo_full, overflow
`ifdef LDTU_ENC_OVF_CNT_EN
    , output ovf_cnt
`endif
  );
endinterface

// File: rtl/ldtu_data_encoder.sv
// Packs baseline (5x6b) / signal (2x13b) samples into 32-bit words, buffered in an output FIFO.
// Latency: word written at the edge accepting its completing sample; visible right after (FWFT).
// Backpressure: word_valid/word_ready; pushes into a full FIFO without a pop are dropped (overflow).
// Ports: CLK, reset (async, active-low), bus (ldtu_data_encoder_if.slave).
// Optional macro LDTU_ENC_OVF_CNT_EN: adds bus.ovf_cnt, a saturating count of dropped words.
module ldtu_data_encoder #(
  parameter int unsigned OFIFO_DEPTH = 8,
  parameter logic [31:0] IDLE_WORD   = 32'hEAAAAAAA
) (
  input logic               CLK,
  input logic               reset,
  ldtu_data_encoder_if.slave bus
);
  localparam int unsigned AW = $clog2(OFIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_BASE, S_SIG} state_t;

  state_t      state, state_nxt, a_state;
  logic [2:0]  cnt, cnt_nxt, a_cnt;
  logic [23:0] acc, acc_nxt, a_acc;
  logic [12:0] hold, hold_nxt, a_hold;
  logic        flush_pend, flush_pend_nxt, flush_any;
  logic        smp_push;
  logic        push_vld;
  logic [31:0] push_dat;

  assign flush_any = bus.flush | flush_pend;

  // State register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      acc        <= '0;
      hold       <= '0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      acc        <= acc_nxt;
      hold       <= hold_nxt;
      flush_pend <= flush_pend_nxt;
    end
  end

  // Next state: absorb the sample first (a_*), then apply flush on top of that.
  always_comb begin
    a_state  = state;
    a_cnt    = cnt;
    a_acc    = acc;
    a_hold   = hold;
    smp_push = 1'b0;
    if (bus.sample_valid) begin
      unique case (state)
        S_IDLE: begin
          if (bus.baseline_flag) begin
            a_state = S_BASE;
            a_cnt   = 3'd1;
            a_acc   = {18'd0, bus.DATA_to_enc[5:0]};
          end else begin
            a_state = S_SIG;
            a_hold  = bus.DATA_to_enc;
          end
        end
        S_BASE: begin
          if (bus.baseline_flag && cnt != 3'd4) begin
            a_cnt = cnt + 3'd1;
            a_acc = acc | (24'(bus.DATA_to_enc[5:0]) << (6 * cnt));
          end else if (bus.baseline_flag) begin
            smp_push = 1'b1;
            a_state  = S_IDLE;
            a_cnt    = '0;
            a_acc    = '0;
          end else begin
            smp_push = 1'b1;
            a_state  = S_SIG;
            a_cnt    = '0;
            a_acc    = '0;
            a_hold   = bus.DATA_to_enc;
          end
        end
        S_SIG: begin
          smp_push = 1'b1;
          a_hold   = '0;
          if (bus.baseline_flag) begin
            a_state = S_BASE;
            a_cnt   = 3'd1;
            a_acc   = {18'd0, bus.DATA_to_enc[5:0]};
          end else begin
            a_state = S_IDLE;
          end
        end
        default: a_state = S_IDLE;
      endcase
    end

    state_nxt      = a_state;
    cnt_nxt        = a_cnt;
    acc_nxt        = a_acc;
    hold_nxt       = a_hold;
    flush_pend_nxt = 1'b0;
    // Only one word per cycle: if the sample already produced one, the partial waits a cycle.
    if (flush_any && a_state != S_IDLE) begin
      if (smp_push) begin
        flush_pend_nxt = 1'b1;
      end else begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        acc_nxt   = '0;
        hold_nxt  = '0;
      end
    end
  end

  // Output: the word pushed this cycle
  always_comb begin
    push_vld = 1'b0;
    push_dat = '0;
    if (bus.sample_valid) begin
      unique case (state)
        S_BASE: begin
          if (!bus.baseline_flag) begin
            push_vld = 1'b1;
            push_dat = {4'b0010, cnt, 1'b0, acc};
          end else if (cnt == 3'd4) begin
            push_vld = 1'b1;
            push_dat = {2'b01, bus.DATA_to_enc[5:0], acc};
          end
        end
        S_SIG: begin
          push_vld = 1'b1;
          push_dat = bus.baseline_flag ? {6'b101011, 13'd0, hold}
                                       : {6'b101010, bus.DATA_to_enc, hold};
        end
        default: ;
      endcase
    end
    if (!smp_push && flush_any) begin
      unique case (a_state)
        S_BASE: begin
          push_vld = 1'b1;
          push_dat = {4'b0010, a_cnt, 1'b0, a_acc};
        end
        S_SIG: begin
          push_vld = 1'b1;
          push_dat = {6'b101011, 13'd0, a_hold};
        end
        default: ;
      endcase
    end
  end

  // Output FIFO (first-word fall-through)
  logic [31:0]   mem [OFIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_empty, full, pop, wr_en, drop;
  logic          overflow_q;

  assign fifo_empty = (count == '0);
  assign full       = (count == (AW+1)'(OFIFO_DEPTH));
  assign pop        = bus.word_valid & bus.word_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign wr_en      = push_vld & (~full | pop);
  assign drop       = push_vld & full & ~pop;

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign bus.DATA_32    = fifo_empty ? IDLE_WORD : mem[rd_ptr];
  assign bus.word_valid = ~fifo_empty;
  assign bus.fifo_full  = full;
  assign bus.overflow   = overflow_q;

`ifdef LDTU_ENC_OVF_CNT_EN
  logic [7:0] ovf_q;
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)                      ovf_q <= '0;
    else if (drop && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
  end
  assign bus.ovf_cnt = ovf_q;
`endif
endmodule

// File: tb/tb_ldtu_data_encoder.sv
`timescale 1ns/1ps
module tb_ldtu_data_encoder;
  localparam int          DEPTH = 8;
  localparam logic [31:0] IDLE  = 32'hEAAAAAAA;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  ldtu_data_encoder_if enc_if();

  ldtu_data_encoder #(.OFIFO_DEPTH(DEPTH), .IDLE_WORD(IDLE)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (enc_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard: words expected to be sitting in the DUT FIFO, oldest first.
  logic [31:0] sb[$];
  int          drops = 0;

  // Reference packer state: samples collected for the word under construction.
  logic [5:0]  base_q[$];
  logic [12:0] sig_q[$];
  bit          m_flpend = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] base_word();
    logic [31:0] w = '0;
    for (int i = 0; i < base_q.size(); i++) w = w | (32'(base_q[i]) << (6 * i));
    if (base_q.size() == 5) w[31:30] = 2'b01;
    else begin
      w[31:28] = 4'b0010;
      w[27:25] = 3'(base_q.size());
    end
    return w;
  endfunction

  function automatic logic [31:0] sig_word();
    if (sig_q.size() == 2) return {6'b101010, sig_q[1], sig_q[0]};
    return {6'b101011, 13'd0, sig_q[0]};
  endfunction

  task automatic model_step(input bit v, input bit bf, input logic [12:0] d, input bit fl,
                            output bit pushed, output logic [31:0] w);
    bit fa;
    fa       = fl | m_flpend;
    m_flpend = 1'b0;
    pushed   = 1'b0;
    w        = '0;
    if (v) begin
      if (bf) begin
        if (sig_q.size() != 0) begin w = sig_word(); pushed = 1'b1; sig_q.delete(); end
        base_q.push_back(d[5:0]);
        if (base_q.size() == 5) begin w = base_word(); pushed = 1'b1; base_q.delete(); end
      end else begin
        if (base_q.size() != 0) begin w = base_word(); pushed = 1'b1; base_q.delete(); end
        sig_q.push_back(d);
        if (sig_q.size() == 2) begin w = sig_word(); pushed = 1'b1; sig_q.delete(); end
      end
    end
    if (fa && (base_q.size() + sig_q.size()) != 0) begin
      if (pushed) m_flpend = 1'b1;
      else if (base_q.size() != 0) begin w = base_word(); pushed = 1'b1; base_q.delete(); end
      else begin w = sig_word(); pushed = 1'b1; sig_q.delete(); end
    end
  endtask

  task automatic model_clear();
    base_q.delete();
    sig_q.delete();
    sb.delete();
    m_flpend = 1'b0;
    drops    = 0;
  endtask

  // One clock cycle, entered and left on the falling edge.
  task automatic step(input bit v, input bit bf, input logic [12:0] d, input bit fl, input bit rdy);
    bit          p;
    logic [31:0] w;
    enc_if.sample_valid  = v;
    enc_if.baseline_flag = bf;
    enc_if.DATA_to_enc   = d;
    enc_if.flush         = fl;
    enc_if.word_ready    = rdy;
    #1;
    check_val("word_valid", 32'(enc_if.word_valid), 32'(sb.size() != 0));
    check_val("fifo_full",  32'(enc_if.fifo_full),  32'(sb.size() == DEPTH));
    check_val("overflow",   32'(enc_if.overflow),   32'(drops != 0));
`ifdef LDTU_ENC_OVF_CNT_EN
    check_val("ovf_cnt", 32'(enc_if.ovf_cnt), (drops > 255) ? 32'd255 : 32'(drops));
`endif
    check_val("DATA_32", enc_if.DATA_32, (sb.size() != 0) ? sb[0] : IDLE);
    if (rdy && sb.size() != 0) void'(sb.pop_front());
    model_step(v, bf, d, fl, p, w);
    if (p) begin
      if (sb.size() < DEPTH) sb.push_back(w);
      else drops++;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic base(input logic [12:0] d, input bit rdy);
    step(1'b1, 1'b1, d, 1'b0, rdy);
  endtask

  task automatic sig(input logic [12:0] d, input bit rdy);
    step(1'b1, 1'b0, d, 1'b0, rdy);
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * DEPTH && sb.size() != 0; i++) step(1'b0, 1'b0, 13'd0, 1'b0, 1'b1);
    check_val("drain_timeout", 32'(sb.size()), 32'd0);
    step(1'b0, 1'b0, 13'd0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    #1;
    check_val("rst_DATA_32",    enc_if.DATA_32,              IDLE);
    check_val("rst_word_valid", 32'(enc_if.word_valid),      32'd0);
    check_val("rst_fifo_full",  32'(enc_if.fifo_full),       32'd0);
    check_val("rst_overflow",   32'(enc_if.overflow),        32'd0);
    repeat (2) @(negedge CLK);
    reset = 1'b1;
  endtask

  initial begin
    enc_if.sample_valid  = 1'b0;
    enc_if.baseline_flag = 1'b0;
    enc_if.DATA_to_enc   = '0;
    enc_if.flush         = 1'b0;
    enc_if.word_ready    = 1'b0;
    reset                = 1'b0;
    @(negedge CLK);
    do_reset();

    // Five baseline samples -> BASE_FULL
    for (int i = 1; i <= 5; i++) base(13'(i), 1'b1);
    drain();

    // Two signal samples -> SIG_PAIR
    sig(13'h1ABC, 1'b1);
    sig(13'h0123, 1'b1);
    drain();

    // Partial baseline closed by a signal, then flush with the same sample (pending flush)
    base(13'h003F, 1'b1);
    base(13'h0001, 1'b1);
    step(1'b1, 1'b0, 13'h1FFF, 1'b1, 1'b1);
    step(1'b0, 1'b0, 13'd0, 1'b0, 1'b1);
    drain();

    // Plain flush cases: baseline+flush same cycle, lone signal then flush, flush in IDLE
    step(1'b1, 1'b1, 13'h0015, 1'b1, 1'b1);
    sig(13'h0A5A, 1'b1);
    step(1'b0, 1'b0, 13'd0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 13'd0, 1'b1, 1'b1);
    drain();

    // Backpressure: 40 signals with no consumer -> full FIFO, 12 drops
    for (int i = 0; i < 40; i++) sig(13'(16'h0100 + i), 1'b0);
    drain();

    // Async reset with three baseline samples held
    for (int i = 0; i < 3; i++) base(13'(6'h20 + i), 1'b1);
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    check_val("async_DATA_32",  enc_if.DATA_32,         IDLE);
    check_val("async_overflow", 32'(enc_if.overflow),   32'd0);
    @(negedge CLK);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) base(13'(6'h30 + i), 1'b1);
    drain();

    // Full FIFO with simultaneous push and pop: nothing dropped
    for (int i = 0; i < 16; i++) sig(13'(16'h0200 + i), 1'b0);
    for (int i = 0; i < 6; i++)  sig(13'(16'h0300 + i), 1'b1);
    drain();

    // Random mix
    for (int i = 0; i < 400; i++) begin
      bit v;
      v = ($urandom_range(0, 3) != 0) && !m_flpend;
      step(v, 1'($urandom_range(0, 1)), 13'($urandom), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) != 0));
    end
    step(1'b0, 1'b0, 13'd0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 13'd0, 1'b0, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
